// File: rtl/lcm_pkg.sv
// Shared types for the intersection light-bus conflict monitor.
// Optional fault_clear port is enabled by LCM_FAULT_CLEAR_EN.
package lcm_pkg;

    localparam logic [1:0] LC_OFF = 2'd0;
    localparam logic [1:0] LC_RED = 2'd1;
    localparam logic [1:0] LC_YEL = 2'd2;
    localparam logic [1:0] LC_GRN = 2'd3;

    localparam logic [2:0] LAMP_OFF = 3'b000;
    localparam logic [2:0] LAMP_RED = 3'b001;

    typedef enum logic [2:0] {
        FLT_NONE     = 3'd0,
        FLT_CONFLICT = 3'd1,
        FLT_ILLEGAL  = 3'd2,
        FLT_SHORT_Y  = 3'd3,
        FLT_STALL    = 3'd4
    } fault_t;

    typedef enum logic [1:0] {
        INIT,
        RUN,
        FAULT
    } state_t;

    // One-hot {G,Y,R}; code 0 lights nothing.
    function automatic logic [2:0] decode_lamp(input logic [1:0] code);
        logic [2:0] lamp;
        lamp = LAMP_OFF;
        unique case (code)
            LC_RED:  lamp = 3'b001;
            LC_YEL:  lamp = 3'b010;
            LC_GRN:  lamp = 3'b100;
            default: lamp = LAMP_OFF;
        endcase
        return lamp;
    endfunction

endpackage

// File: rtl/lcm_approach_checker.sv
// Per-approach sequence checker: previous code, yellow dwell,
// illegal-transition and short-yellow flags.
module lcm_approach_checker
    import lcm_pkg::*;
#(
    parameter int MIN_YEL = 2,
    parameter int CW      = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] code,
    input  logic       load,
    input  logic       step,
    output logic [1:0] prev_code,
    output logic       illegal,
    output logic       short_y
);

    localparam logic [CW-1:0] DWELL_SAT = CW'(MIN_YEL + 1);
    localparam logic [CW-1:0] DWELL_MIN = CW'(MIN_YEL);

    logic [CW-1:0] dwell;

    always_comb begin
        illegal = 1'b0;
        if (code != prev_code) begin
            unique case (prev_code)
                LC_GRN:  illegal = (code != LC_YEL);
                LC_YEL:  illegal = (code == LC_OFF);
                LC_RED:  illegal = (code != LC_YEL);
                default: illegal = 1'b1;
            endcase
        end
    end

    assign short_y = (prev_code == LC_YEL) && (code != LC_YEL)
                     && (dwell < DWELL_MIN);

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_code <= LC_OFF;
            dwell     <= '0;
        end else if (load || step) begin
            prev_code <= code;
            if (code != LC_YEL)
                dwell <= '0;
            else if (load || prev_code != LC_YEL)
                dwell <= CW'(1);
            else if (dwell < DWELL_SAT)
                dwell <= dwell + 1'b1;
        end
    end

endmodule

// File: rtl/light_conflict_monitor.sv
// Light-bus receiver: decodes main/side codes to lamps and latches faults.
// Define LCM_FAULT_CLEAR_EN to add the fault_clear port.
module light_conflict_monitor
    import lcm_pkg::*;
#(
    parameter int MIN_YEL    = 2,
    parameter int MAX_HOLD   = 31,
    parameter int FLASH_HALF = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] main_code,
    input  logic [1:0] side_code,
`ifdef LCM_FAULT_CLEAR_EN
    input  logic       fault_clear,
`endif
    output logic [2:0] main_lamp,
    output logic [2:0] side_lamp,
    output logic       fault,
    output logic [2:0] fault_code
);

    localparam int CW = $clog2(MAX_HOLD + 2);
    localparam int FW = $clog2(FLASH_HALF + 1);
    localparam logic [CW-1:0] STALL_SAT = CW'(MAX_HOLD + 1);
    localparam logic [CW-1:0] STALL_LIM = CW'(MAX_HOLD);
    localparam logic [FW-1:0] FLASH_END = FW'(FLASH_HALF);

    state_t        state;
    fault_t        fault_id;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] stall_nxt;
    logic [FW-1:0] flash_cnt;
    logic          flash_on;
    logic [1:0]    main_prev, side_prev;
    logic          main_ill, side_ill;
    logic          main_short, side_short;
    logic          both_live, both_off;
    logic          conflict, load, step, clear_req;

    assign both_live = (main_code != LC_OFF) && (side_code != LC_OFF);
    assign both_off  = (main_code == LC_OFF) && (side_code == LC_OFF);
    assign load      = (state == INIT) && both_live;
    assign step      = (state == RUN) && (fault_id == FLT_NONE);

`ifdef LCM_FAULT_CLEAR_EN
    assign clear_req = fault_clear && both_off;
`else
    assign clear_req = 1'b0;
`endif

    assign conflict = ((main_code == LC_GRN) && (side_code != LC_RED))
                   || ((side_code == LC_GRN) && (main_code != LC_RED));

    always_comb begin
        stall_nxt = '0;
        if ({main_code, side_code} == {main_prev, side_prev})
            stall_nxt = (stall_cnt == STALL_SAT) ? stall_cnt
                                                 : stall_cnt + 1'b1;
    end

    // Lowest-numbered cause wins when several fire together.
    always_comb begin
        fault_id = FLT_NONE;
        if (conflict)
            fault_id = FLT_CONFLICT;
        else if (main_ill || side_ill)
            fault_id = FLT_ILLEGAL;
        else if (main_short || side_short)
            fault_id = FLT_SHORT_Y;
        else if (stall_nxt > STALL_LIM)
            fault_id = FLT_STALL;
    end

    lcm_approach_checker #(.MIN_YEL(MIN_YEL), .CW(CW)) u_main (
        .clk       (clk),
        .reset     (reset),
        .code      (main_code),
        .load      (load),
        .step      (step),
        .prev_code (main_prev),
        .illegal   (main_ill),
        .short_y   (main_short)
    );

    lcm_approach_checker #(.MIN_YEL(MIN_YEL), .CW(CW)) u_side (
        .clk       (clk),
        .reset     (reset),
        .code      (side_code),
        .load      (load),
        .step      (step),
        .prev_code (side_prev),
        .illegal   (side_ill),
        .short_y   (side_short)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= INIT;
            main_lamp  <= LAMP_OFF;
            side_lamp  <= LAMP_OFF;
            fault      <= 1'b0;
            fault_code <= FLT_NONE;
            stall_cnt  <= '0;
            flash_cnt  <= '0;
            flash_on   <= 1'b0;
        end else begin
            unique case (state)
                INIT: begin
                    if (both_live) begin
                        state     <= RUN;
                        main_lamp <= decode_lamp(main_code);
                        side_lamp <= decode_lamp(side_code);
                        stall_cnt <= '0;
                    end
                end
                RUN: begin
                    if (fault_id != FLT_NONE) begin
                        state      <= FAULT;
                        fault      <= 1'b1;
                        fault_code <= fault_id;
                        main_lamp  <= LAMP_RED;
                        side_lamp  <= LAMP_RED;
                        flash_cnt  <= FW'(1);
                        flash_on   <= 1'b1;
                    end else begin
                        main_lamp <= decode_lamp(main_code);
                        side_lamp <= decode_lamp(side_code);
                        stall_cnt <= stall_nxt;
                    end
                end
                FAULT: begin
                    if (clear_req) begin
                        state      <= INIT;
                        main_lamp  <= LAMP_OFF;
                        side_lamp  <= LAMP_OFF;
                        fault      <= 1'b0;
                        fault_code <= FLT_NONE;
                        stall_cnt  <= '0;
                        flash_cnt  <= '0;
                        flash_on   <= 1'b0;
                    end else if (flash_cnt == FLASH_END) begin
                        flash_cnt <= FW'(1);
                        flash_on  <= !flash_on;
                        main_lamp <= flash_on ? LAMP_OFF : LAMP_RED;
                        side_lamp <= flash_on ? LAMP_OFF : LAMP_RED;
                    end else begin
                        flash_cnt <= flash_cnt + 1'b1;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_light_conflict_monitor.sv
// Table-driven bench for light_conflict_monitor with an expectation queue.
// Clear-path vectors are included when LCM_FAULT_CLEAR_EN is defined.
module tb_light_conflict_monitor;

    typedef struct {
        logic       rst;
        logic       clr;
        logic [1:0] m;
        logic [1:0] s;
        logic [2:0] ml;
        logic [2:0] sl;
        logic       flt;
        logic [2:0] fc;
    } vec_t;

    localparam logic [2:0] L0 = 3'b000;
    localparam logic [2:0] LR = 3'b001;
    localparam logic [2:0] LY = 3'b010;
    localparam logic [2:0] LG = 3'b100;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] main_code;
    logic [1:0] side_code;
`ifdef LCM_FAULT_CLEAR_EN
    logic       fault_clear;
`endif
    logic [2:0] main_lamp;
    logic [2:0] side_lamp;
    logic       fault;
    logic [2:0] fault_code;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    light_conflict_monitor dut (
        .clk         (clk),
        .reset       (reset),
        .main_code   (main_code),
        .side_code   (side_code),
`ifdef LCM_FAULT_CLEAR_EN
        .fault_clear (fault_clear),
`endif
        .main_lamp   (main_lamp),
        .side_lamp   (side_lamp),
        .fault       (fault),
        .fault_code  (fault_code)
    );

    function automatic void addc(
        input logic rst, input logic clr,
        input logic [1:0] m, input logic [1:0] s,
        input logic [2:0] ml, input logic [2:0] sl,
        input logic flt, input logic [2:0] fc);
        vec_t v;
        v.rst = rst; v.clr = clr; v.m = m; v.s = s;
        v.ml = ml; v.sl = sl; v.flt = flt; v.fc = fc;
        tbl.push_back(v);
    endfunction

    function automatic void add(
        input logic rst,
        input logic [1:0] m, input logic [1:0] s,
        input logic [2:0] ml, input logic [2:0] sl,
        input logic flt, input logic [2:0] fc);
        addc(rst, 1'b0, m, s, ml, sl, flt, fc);
    endfunction

    task automatic check(input int idx);
        vec_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL vec%0d: scoreboard empty", idx);
        end else begin
            e = exp_q.pop_front();
            if (main_lamp !== e.ml || side_lamp !== e.sl ||
                fault !== e.flt || fault_code !== e.fc) begin
                bad++;
                $display("FAIL vec%0d: got ml=%b sl=%b f=%b fc=%0d want ml=%b sl=%b f=%b fc=%0d",
                         idx, main_lamp, side_lamp, fault, fault_code,
                         e.ml, e.sl, e.flt, e.fc);
            end
        end
    endtask

    initial begin
        // reset and idle INIT
        add(1, 0, 0, L0, L0, 0, 0);
        add(1, 0, 0, L0, L0, 0, 0);
        add(0, 0, 0, L0, L0, 0, 0);
        add(0, 0, 0, L0, L0, 0, 0);
        add(0, 3, 0, L0, L0, 0, 0);
        add(0, 0, 1, L0, L0, 0, 0);
        // legal cycle
        for (int i = 0; i < 6; i++) add(0, 3, 1, LG, LR, 0, 0);
        for (int i = 0; i < 2; i++) add(0, 2, 2, LY, LY, 0, 0);
        for (int i = 0; i < 6; i++) add(0, 1, 3, LR, LG, 0, 0);
        for (int i = 0; i < 2; i++) add(0, 2, 2, LY, LY, 0, 0);
        // conflict then red flash, inputs ignored
        add(0, 3, 3, LR, LR, 1, 1);
        for (int i = 0; i < 3; i++) add(0, 0, 0, LR, LR, 1, 1);
        for (int i = 0; i < 4; i++) add(0, 3, 1, L0, L0, 1, 1);
        for (int i = 0; i < 4; i++) add(0, 0, 0, LR, LR, 1, 1);
        for (int i = 0; i < 2; i++) add(0, 1, 3, L0, L0, 1, 1);
        add(1, 3, 1, L0, L0, 0, 0);
        // illegal G->R
        add(0, 3, 1, LG, LR, 0, 0);
        add(0, 3, 1, LG, LR, 0, 0);
        add(0, 1, 1, LR, LR, 1, 2);
        add(0, 1, 1, LR, LR, 1, 2);
        add(1, 0, 0, L0, L0, 0, 0);
        // short yellow
        add(0, 3, 1, LG, LR, 0, 0);
        add(0, 2, 1, LY, LR, 0, 0);
        add(0, 1, 1, LR, LR, 1, 3);
        add(1, 0, 0, L0, L0, 0, 0);
        // stall: 32 unchanged samples after entry
        for (int i = 0; i < 32; i++) add(0, 1, 3, LR, LG, 0, 0);
        add(0, 1, 3, LR, LR, 1, 4);
        add(1, 0, 0, L0, L0, 0, 0);
        // conflict and illegal together
        add(0, 3, 1, LG, LR, 0, 0);
        add(0, 3, 3, LR, LR, 1, 1);
        add(1, 0, 0, L0, L0, 0, 0);
        // illegal and short together: Y->0
        add(0, 3, 1, LG, LR, 0, 0);
        add(0, 2, 1, LY, LR, 0, 0);
        add(0, 0, 1, LR, LR, 1, 2);
        add(1, 0, 0, L0, L0, 0, 0);
        // reset mid-RUN
        add(0, 3, 1, LG, LR, 0, 0);
        add(1, 3, 1, L0, L0, 0, 0);
        add(0, 0, 0, L0, L0, 0, 0);
`ifdef LCM_FAULT_CLEAR_EN
        add(0, 3, 1, LG, LR, 0, 0);
        add(0, 3, 3, LR, LR, 1, 1);
        addc(0, 1, 1, 3, LR, LR, 1, 1);
        addc(0, 1, 0, 0, L0, L0, 0, 0);
        add(0, 3, 1, LG, LR, 0, 0);
        add(1, 0, 0, L0, L0, 0, 0);
`endif

        foreach (tbl[i]) begin
            reset     = tbl[i].rst;
            main_code = tbl[i].m;
            side_code = tbl[i].s;
`ifdef LCM_FAULT_CLEAR_EN
            fault_clear = tbl[i].clr;
`endif
            exp_q.push_back(tbl[i]);
            @(posedge clk);
            #1;
            check(i);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
